// File: rtl/iq_demod_pkg.sv
// Shared types and saturation limits for the IQ demodulator datapath.
package iq_demod_pkg;

  // Widest accumulator the result record can carry.
  localparam int unsigned RES_WIDTH = 32;

  function automatic logic [RES_WIDTH-1:0] acc_max(input int unsigned w);
    return (RES_WIDTH'(1) << (w - 1)) - RES_WIDTH'(1);
  endfunction

  function automatic logic [RES_WIDTH-1:0] acc_min(input int unsigned w);
    return RES_WIDTH'(1) << (w - 1);
  endfunction

  typedef struct packed {
    logic signed [RES_WIDTH-1:0] i;
    logic signed [RES_WIDTH-1:0] q;
    logic                        sat;
  } iq_result_t;

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder with carry-lookahead and optional clamping.
// overflow flags a same-sign operand pair whose raw sum changed sign.
module sat_add
  import iq_demod_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter logic        SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(acc_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(acc_min(WIDTH));

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] raw;

  // Carry into bit k: some lower bit generates and every bit above it propagates.
  function automatic logic cla_carry(input logic [WIDTH-1:0] g,
                                     input logic [WIDTH-1:0] p,
                                     input int unsigned k);
    logic c;
    logic t;
    c = 1'b0;
    for (int unsigned j = 0; j < k; j++) begin
      t = g[j];
      for (int unsigned m = j + 1; m < k; m++) begin
        t = t & p[m];
      end
      c = c | t;
    end
    return c;
  endfunction

  assign gen      = a & b;
  assign prop     = a ^ b;
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_cla
      assign carry[gi] = cla_carry(gen, prop, gi);
    end
  endgenerate

  assign raw      = prop ^ carry;
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    sum = raw;
    if (SATURATE && overflow) begin
      sum = a[WIDTH-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/iq_integrate_dump.sv
// Dual-channel signed integrate-and-dump with programmable length and a
// registered valid/ready result port. ACC_WIDTH must lie in [IN_WIDTH, RES_WIDTH].
module iq_integrate_dump
  import iq_demod_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned LEN_WIDTH = 6,
  parameter logic        SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [LEN_WIDTH-1:0] dump_len,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_i,
  input  logic [IN_WIDTH-1:0]  in_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_i,
  output logic [ACC_WIDTH-1:0] out_q,
  output logic                 out_sat,
  output logic                 overrun
);

  logic [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
  logic [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 sat_q, sat_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrun_q, overrun_d;
  iq_result_t           res_q, res_d;

  logic [ACC_WIDTH-1:0] samp_i, samp_q;
  logic [ACC_WIDTH-1:0] sum_i, sum_q;
  logic                 ovf_i, ovf_q;
  logic [LEN_WIDTH-1:0] start_len, cur_len;
  logic                 accept, last;
  logic                 unused_res_bits;

  assign samp_i = ACC_WIDTH'($signed(in_i));
  assign samp_q = ACC_WIDTH'($signed(in_q));

  sat_add #(.WIDTH(ACC_WIDTH), .SATURATE(SATURATE)) u_add_i (
    .a        (acc_i_q),
    .b        (samp_i),
    .sum      (sum_i),
    .overflow (ovf_i)
  );

  sat_add #(.WIDTH(ACC_WIDTH), .SATURATE(SATURATE)) u_add_q (
    .a        (acc_q_q),
    .b        (samp_q),
    .sum      (sum_q),
    .overflow (ovf_q)
  );

  // The first sample of a dump sees the live dump_len, later ones the captured copy.
  assign start_len = (dump_len == '0) ? LEN_WIDTH'(1) : dump_len;
  assign cur_len   = (count_q == '0) ? start_len : len_q;
  assign accept    = in_valid & ~clear;
  assign last      = accept && (count_q == cur_len - LEN_WIDTH'(1));

  always_comb begin
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    count_d     = count_q;
    len_d       = len_q;
    sat_d       = sat_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (clear) begin
      acc_i_d = '0;
      acc_q_d = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else if (in_valid) begin
      if (count_q == '0) begin
        len_d = start_len;
      end
      if (last) begin
        acc_i_d   = '0;
        acc_q_d   = '0;
        count_d   = '0;
        sat_d     = 1'b0;
        res_d.i   = RES_WIDTH'($signed(sum_i));
        res_d.q   = RES_WIDTH'($signed(sum_q));
        res_d.sat = sat_q | ovf_i | ovf_q;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        count_d = count_q + LEN_WIDTH'(1);
        sat_d   = sat_q | ovf_i | ovf_q;
      end
    end

    // A fresh result always wins; it only counts as lost if nobody took the old one.
    if (last) begin
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      count_q     <= '0;
      len_q       <= LEN_WIDTH'(1);
      sat_q       <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      count_q     <= count_d;
      len_q       <= len_d;
      sat_q       <= sat_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_i     = res_q.i[ACC_WIDTH-1:0];
  assign out_q     = res_q.q[ACC_WIDTH-1:0];
  assign out_sat   = res_q.sat;
  assign overrun   = overrun_q;

  // Upper bits of the shared result record are sign copies and never leave the block.
  assign unused_res_bits = ^res_q;

endmodule

// File: doc/iq_integrate_dump.md
Name: iq_integrate_dump

Overview:
- Dual-channel (I/Q) signed integrate-and-dump accumulator for the IQ demodulator.
- Sums a programmable number of consecutive valid I/Q samples per channel, then presents the pair of sums on a registered valid/ready output and restarts.
- Generalises the team's combinational signed adder: parametrised widths, sequential accumulation, saturating arithmetic, programmable dump length, and an output handshake.
- Sits between the mixer/decimator output and the chip/symbol decision logic.

Parameters:
- IN_WIDTH, 8, signed width of each input sample.
- ACC_WIDTH, 16, signed accumulator and output width; must be >= IN_WIDTH.
- LEN_WIDTH, 6, width of the dump-length control.
- SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of the current dump; does not touch the output register.
- dump_len  in  LEN_WIDTH  samples per dump; 0 is treated as 1; sampled at dump start.
- in_valid  in  1  input sample strobe; no backpressure, a sample is accepted every cycle in_valid=1.
- in_i  in  IN_WIDTH  signed I sample.
- in_q  in  IN_WIDTH  signed Q sample.
- out_valid  out  1  result pair available.
- out_ready  in  1  consumer accepts the result when out_valid & out_ready.
- out_i  out  ACC_WIDTH  signed I sum.
- out_q  out  ACC_WIDTH  signed Q sum.
- out_sat  out  1  at least one saturation event in this dump (either channel).
- overrun  out  1  sticky; an unconsumed result was overwritten; cleared only by rst.

Behaviour:
Reset (rst=1 at a clock edge):
- acc_i = acc_q = 0, count = 0, len_q = 1.
- out_valid = 0, out_i = out_q = 0, out_sat = 0, overrun = 0.
- rst has priority over every other input, including mid-dump.

Dump length:
- len_q <= max(dump_len, 1), captured on a cycle with in_valid=1 and count=0.
- A dump_len change mid-dump takes effect from the next dump.

Accumulate:
- Each accepted sample is sign-extended to ACC_WIDTH and added to acc.
- If SATURATE=1: overflow is detected when both operands have the same sign and the sum sign differs. The result clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), and the internal sat flag is set.
- If SATURATE=0: the sum wraps, and the sat flag is set on the same overflow condition.

Counter:
- count increments per accepted sample.
- On the sample where count = len_q-1 (last sample): count <= 0, acc <= 0, sat flag <= 0.
- The sum including that last sample is loaded into out_i/out_q/out_sat, and out_valid <= 1.
- Latency: out_valid rises on the clock edge following the cycle the last sample is presented, i.e. one register stage.

Output handshake:
- out_valid/out_i/out_q/out_sat stay stable while out_valid=1 and out_ready=0.
- out_valid & out_ready & no new result: out_valid <= 0.
- New result on the same cycle as out_valid & out_ready: new data loads, out_valid stays 1, no overrun.
- New result while out_valid=1 & out_ready=0: new data overwrites, and overrun <= 1.

clear:
- count <= 0, acc <= 0, sat flag <= 0; any in_valid sample in that cycle is discarded.
- Output register and overrun are unaffected. rst has priority over clear.

Idle:
- in_valid=0 leaves acc, count and sat unchanged; gaps inside a dump are allowed.

Decomposition:
- Package iq_demod_pkg: ACC_MAX/ACC_MIN as functions of width, and a typedef struct {i, q, sat} for the result pair.
- One sub-module: sat_add, a parametrised combinational signed adder (WIDTH, SATURATE) returning sum and overflow. It is instantiated once per channel and reuses the team's lookahead adder structure internally.

Test Plan:
- Reset/basic: IN=8, ACC=16, dump_len=4, I samples 1,2,3,4 and Q samples -1,-2,-3,-4 on consecutive cycles -> out_valid one cycle after the 4th sample, out_i=10, out_q=-10, out_sat=0; all outputs are 0 while rst is held.
- Saturation: ACC_WIDTH=8, dump_len=3, I=127,127,127 -> out_i=127, out_sat=1. The same stimulus with SATURATE=0 -> out_i=125 (wrapped), out_sat=1. I=-128,-128 with dump_len=2 -> out_i=-128, out_sat=1.
- Backpressure/overrun: dump_len=1, out_ready=0, samples 5 then 7 -> out_i holds 5 for one cycle, then becomes 7 with overrun=1. With out_ready=1 on the same stimulus -> overrun stays 0.
- Gaps and length change: dump_len=3, valid pattern 1,0,1,0,0,1 with I=2 -> out_i=6. Changing dump_len to 2 after the first sample does not affect that dump; the next dump uses 2.
- dump_len=0 -> every sample produces an output equal to the sign-extended sample, e.g. in_i=-3 -> out_i=-3.
- clear and rst mid-dump: dump_len=4, two samples of 9 then clear, then four samples of 1 -> out_i=4. rst asserted after two samples -> out_valid=0, and the next 4 samples produce a fresh sum.
